// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants and struct bundles for the multi-port register file.
//   XLEN_DEF / REG_DEPTH_DEF : default data width and register count
//   regfile_mp_in_type       : decode/writeback request bundle (default geometry)
//   regfile_mp_out_type      : read data, busy lookups and busy_any bundle
package regfile_mp_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_DEPTH_DEF = 32;
  localparam int NR_DEF = 2;
  localparam int NW_DEF = 1;
  localparam int AW_DEF = $clog2(REG_DEPTH_DEF);
  typedef struct packed {
    logic [NR_DEF-1:0]                rden;
    logic [NR_DEF-1:0][AW_DEF-1:0]    raddr;
    logic [NW_DEF-1:0]                wren;
    logic [NW_DEF-1:0][AW_DEF-1:0]    waddr;
    logic [NW_DEF-1:0][XLEN_DEF-1:0]  wdata;
    logic                             lock_en;
    logic [AW_DEF-1:0]                lock_addr;
    logic                             flush;
  } regfile_mp_in_type;
  typedef struct packed {
    logic [NR_DEF-1:0][XLEN_DEF-1:0]  rdata;
    logic [NR_DEF-1:0]                rbusy;
    logic                             busy_any;
  } regfile_mp_out_type;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for outstanding multi-cycle producers.
//   clk, rst                  : clock, synchronous active-high reset
//   lock_en_i, lock_addr_i    : mark a register busy
//   flush_i                   : clear every busy bit (drops a same-cycle lock)
//   wren_i, waddr_i           : writebacks retire the busy bit of their target
//   rden_i, raddr_i, rbusy_o  : NR stored-state lookups, gated by rden_i
//   busy_any_o                : OR of all busy bits
module regfile_scoreboard import regfile_mp_pkg::*; #(
  parameter int DEPTH    = REG_DEPTH_DEF,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  lock_en_i,
  input  logic [$clog2(DEPTH)-1:0]              lock_addr_i,
  input  logic                                  flush_i,
  input  logic [NW-1:0]                         wren_i,
  input  logic [NW-1:0][$clog2(DEPTH)-1:0]      waddr_i,
  input  logic [NR-1:0]                         rden_i,
  input  logic [NR-1:0][$clog2(DEPTH)-1:0]      raddr_i,
  output logic [NR-1:0]                         rbusy_o,
  output logic                                  busy_any_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] busy_q, busy_d;
  // Priority per bit, lowest to highest: hold, write clear, lock set, flush/zero-reg clear.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      busy_d[k] = busy_q[k];
      for (int j = 0; j < NW; j++)
        if (wren_i[j] && waddr_i[j] == AW'(k)) busy_d[k] = 1'b0;
      if (lock_en_i && lock_addr_i == AW'(k)) busy_d[k] = 1'b1;
      if (flush_i || (ZERO_REG != 0 && k == 0)) busy_d[k] = 1'b0;
    end
  end
  always_ff @(posedge clk) busy_q <= rst ? '0 : busy_d;
  always_comb
    for (int i = 0; i < NR; i++) rbusy_o[i] = rden_i[i] & busy_q[raddr_i[i]];
  assign busy_any_o = |busy_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NR-read / NW-write integer register file with busy-bit scoreboard.
//   clk, rst                       : clock, synchronous active-high reset
//   rden_i, raddr_i -> rdata_o     : combinational reads (0 when disabled)
//   rbusy_o                        : busy bit of each read address, 0 when disabled
//   wren_i, waddr_i, wdata_i       : writeback ports, highest index wins on conflict
//   lock_en_i, lock_addr_i, flush_i: scoreboard set / global clear
//   busy_any_o                     : any register still busy
// Build option: define REGISTER_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp import regfile_mp_pkg::*; #(
  parameter int XLEN     = XLEN_DEF,
  parameter int DEPTH    = REG_DEPTH_DEF,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NR-1:0]                         rden_i,
  input  logic [NR-1:0][$clog2(DEPTH)-1:0]      raddr_i,
  output logic [NR-1:0][XLEN-1:0]               rdata_o,
  output logic [NR-1:0]                         rbusy_o,
  input  logic [NW-1:0]                         wren_i,
  input  logic [NW-1:0][$clog2(DEPTH)-1:0]      waddr_i,
  input  logic [NW-1:0][XLEN-1:0]               wdata_i,
  input  logic                                  lock_en_i,
  input  logic [$clog2(DEPTH)-1:0]              lock_addr_i,
  input  logic                                  flush_i,
  output logic                                  busy_any_o
);
  logic [XLEN-1:0] regs_q [DEPTH];
  logic [NR-1:0]   sb_busy;
  logic [NR-1:0]   hit;
  regfile_scoreboard #(.DEPTH(DEPTH), .NR(NR), .NW(NW), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk), .rst(rst),
    .lock_en_i(lock_en_i), .lock_addr_i(lock_addr_i), .flush_i(flush_i),
    .wren_i(wren_i), .waddr_i(waddr_i),
    .rden_i(rden_i), .raddr_i(raddr_i),
    .rbusy_o(sb_busy), .busy_any_o(busy_any_o)
  );
  // Later ports are assigned last, so the highest-indexed writer wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
    end else begin
      for (int j = 0; j < NW; j++)
        if (wren_i[j] && !(ZERO_REG != 0 && waddr_i[j] == '0)) regs_q[waddr_i[j]] <= wdata_i[j];
    end
  end
  always_comb begin
    hit = '0;
    for (int i = 0; i < NR; i++) begin
      rdata_o[i] = (rden_i[i] && !(ZERO_REG != 0 && raddr_i[i] == '0)) ? regs_q[raddr_i[i]] : '0;
`ifdef REGISTER_BYPASS_EN
      for (int j = 0; j < NW; j++)
        if (rden_i[i] && wren_i[j] && waddr_i[j] == raddr_i[i] && !(ZERO_REG != 0 && raddr_i[i] == '0)) begin
          rdata_o[i] = wdata_i[j];
          hit[i] = 1'b1;
        end
`endif
      // A forwarded write retires the producer, unless a new lock lands on the same register.
      rbusy_o[i] = sb_busy[i] & ~(hit[i] & ~(lock_en_i & ~flush_i & (lock_addr_i == raddr_i[i])));
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized scoreboard bench for regfile_mp (NR=2, NW=2, ZERO_REG=1).
module tb_regfile_mp;
  localparam int XL = 32, D = 32, NR = 2, NW = 2, AW = 5;
  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0] rden;
  logic [NR-1:0][AW-1:0] raddr;
  logic [NR-1:0][XL-1:0] rdata;
  logic [NR-1:0] rbusy;
  logic [NW-1:0] wren;
  logic [NW-1:0][AW-1:0] waddr;
  logic [NW-1:0][XL-1:0] wdata;
  logic lock_en, flush, busy_any;
  logic [AW-1:0] lock_addr;
  always #5 clk = ~clk;
  regfile_mp #(.XLEN(XL), .DEPTH(D), .NR(NR), .NW(NW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rden_i(rden), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .wren_i(wren), .waddr_i(waddr), .wdata_i(wdata), .lock_en_i(lock_en),
    .lock_addr_i(lock_addr), .flush_i(flush), .busy_any_o(busy_any)
  );
  typedef struct { logic [XL-1:0] d [NR]; logic b [NR]; logic any; } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  logic [XL-1:0] m_reg [D];
  bit m_busy [D];
  bit m_ok = 0;
  task automatic chk(input string n, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  // One cycle: drive inputs, push expected outputs from the model, then apply the edge to the model.
  task automatic step(input bit r, input logic [1:0] re, input int a0, input int a1,
                      input logic [1:0] we, input int w0, input logic [31:0] d0,
                      input int w1, input logic [31:0] d1, input bit le, input int la, input bit fl);
    exp_t e;
    int a;
    bit hit;
    @(negedge clk);
    rst = r; rden = re; raddr[0] = AW'(a0); raddr[1] = AW'(a1);
    wren = we; waddr[0] = AW'(w0); waddr[1] = AW'(w1); wdata[0] = d0; wdata[1] = d1;
    lock_en = le; lock_addr = AW'(la); flush = fl;
    if (m_ok) begin
      for (int i = 0; i < NR; i++) begin
        a = int'(raddr[i]);
        e.d[i] = '0; e.b[i] = 1'b0;
        hit = 0;
        if (rden[i]) begin
          e.d[i] = m_reg[a]; e.b[i] = m_busy[a];
`ifdef REGISTER_BYPASS_EN
          for (int j = 0; j < NW; j++)
            if (wren[j] && int'(waddr[j]) == a && a != 0) begin e.d[i] = wdata[j]; hit = 1; end
          if (hit && !(le && !fl && la == a)) e.b[i] = 1'b0;
`endif
        end
      end
      e.any = 1'b0;
      for (int k = 0; k < D; k++) e.any |= m_busy[k];
      q.push_back(e);
    end
    if (r) begin
      for (int k = 0; k < D; k++) begin m_reg[k] = '0; m_busy[k] = 0; end
      m_ok = 1;
    end else begin
      for (int j = 0; j < NW; j++)
        if (wren[j]) begin
          if (waddr[j] != 0) m_reg[waddr[j]] = wdata[j];
          m_busy[waddr[j]] = 0;
        end
      if (le && la != 0) m_busy[la] = 1;
      if (fl) for (int k = 0; k < D; k++) m_busy[k] = 0;
      m_busy[0] = 0;
    end
  endtask
  task automatic rd(input int a0, input int a1);
    step(0, 2'b11, a0, a1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < NR; i++) begin
          chk($sformatf("rdata%0d", i), rdata[i], e.d[i]);
          chk($sformatf("rbusy%0d", i), XL'(rbusy[i]), XL'(e.b[i]));
        end
        chk("busy_any", XL'(busy_any), XL'(e.any));
      end
    end
  end
  initial begin
    step(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < D; a++) rd(a, D - 1 - a);
    step(0, 2'b11, 5, 5, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    rd(5, 5);
    step(0, 2'b00, 0, 0, 2'b11, 7, 32'h1111, 7, 32'h2222, 0, 0, 0);
    rd(7, 7);
    step(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 3, 0);
    rd(3, 3);
    step(0, 2'b11, 3, 3, 2'b01, 3, 32'h55, 0, 0, 0, 0, 0);
    rd(3, 3);
    step(0, 2'b00, 0, 0, 2'b10, 0, 0, 4, 32'h44, 1, 4, 0);
    rd(4, 4);
    step(0, 2'b11, 4, 6, 2'b00, 0, 0, 0, 0, 1, 6, 1);
    rd(4, 6);
    step(0, 2'b11, 0, 0, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0);
    rd(0, 0);
    step(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 9, 0);
    step(0, 2'b00, 0, 0, 2'b01, 12, 32'hCAFE, 0, 0, 1, 10, 0);
    rd(9, 12);
    step(1, 2'b11, 9, 12, 2'b01, 9, 32'h99, 0, 0, 1, 12, 0);
    rd(9, 12);
    rd(10, 5);
    for (int n = 0; n < 800; n++)
      step($urandom_range(0, 60) == 0, 2'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
           2'($urandom), $urandom_range(0, 7), $urandom, $urandom_range(0, 7), $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 15) == 0);
    repeat (5) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
